// File: rtl/edge_detector_multi.sv
// Multi-channel debounced edge detector: 2-flop sync, per-channel lockout FSM, registered pulses.
// Optional hold-to-repeat press pulses when EDGE_DETECTOR_AUTOREPEAT_EN is defined.
module edge_detector_multi #(
  parameter int N_CH          = 4,
  parameter int HOLD_CYCLES   = 130000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_CH-1:0] din,
  output logic [N_CH-1:0] rising_pulse,
  output logic [N_CH-1:0] falling_pulse,
  output logic [N_CH-1:0] level,
  output logic            any_rise
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RISE,
    ST_HIGH,
    ST_FALL,
    ST_LOCK
  } state_t;

  logic [N_CH-1:0] sync1_q;
  logic [N_CH-1:0] sync2_q;
  logic            any_rise_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      state_t           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] cnt_sat;
      logic             s;
      logic             rep_fire;
      logic             rise_q, fall_q, level_q;

      assign s       = sync2_q[gi];
      assign cnt_sat = (cnt_q >= HOLD_MAX) ? HOLD_MAX : cnt_q + 1'b1;

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
          ST_IDLE: begin
            if (s) begin
              state_d = ST_RISE;
              cnt_d   = '0;
            end
          end
          ST_RISE: begin
            state_d = ST_HIGH;
            cnt_d   = cnt_sat;
          end
          // Input changes inside the lockout window are treated as bounce.
          ST_HIGH: begin
            cnt_d = cnt_sat;
            if (!s && (cnt_q >= HOLD_MAX)) state_d = ST_FALL;
          end
          ST_FALL: begin
            state_d = ST_LOCK;
            cnt_d   = '0;
          end
          ST_LOCK: begin
            cnt_d = cnt_sat;
            if (cnt_q >= HOLD_MAX) state_d = ST_IDLE;
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        endcase
      end

`ifdef EDGE_DETECTOR_AUTOREPEAT_EN
      // Counts cycles since the last press/repeat pulse; a fire is decided one
      // cycle ahead because the pulse itself is registered.
      localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int REP_W   = $clog2(REP_MAX + 1);
      localparam logic [REP_W-1:0] DELAY_TGT  = REP_W'(REPEAT_DELAY - 2);
      localparam logic [REP_W-1:0] PERIOD_TGT = REP_W'(REPEAT_PERIOD - 2);

      logic [REP_W-1:0] rep_q, rep_d;
      logic             rep_first_q, rep_first_d;
      logic [REP_W-1:0] rep_tgt;

      assign rep_tgt = rep_first_q ? DELAY_TGT : PERIOD_TGT;

      always_comb begin
        rep_d       = rep_q;
        rep_first_d = rep_first_q;
        rep_fire    = 1'b0;
        if (state_q == ST_RISE) begin
          rep_d       = '0;
          rep_first_d = 1'b1;
        end else if ((state_q == ST_HIGH) && rise_q) begin
          rep_d = '0;
        end else if ((state_q == ST_HIGH) && s) begin
          rep_d = rep_q + 1'b1;
          if (rep_q == rep_tgt) begin
            rep_fire    = 1'b1;
            rep_first_d = 1'b0;
          end
        end
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          rep_q       <= '0;
          rep_first_q <= 1'b0;
        end else begin
          rep_q       <= rep_d;
          rep_first_q <= rep_first_d;
        end
      end
`else
      assign rep_fire = 1'b0;
`endif

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          rise_q  <= 1'b0;
          fall_q  <= 1'b0;
          level_q <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          rise_q  <= (state_d == ST_RISE) | rep_fire;
          fall_q  <= (state_d == ST_FALL);
          level_q <= (state_d == ST_RISE) | (state_d == ST_HIGH);
        end
      end

      assign rising_pulse[gi]  = rise_q;
      assign falling_pulse[gi] = fall_q;
      assign level[gi]         = level_q;
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      any_rise_q <= 1'b0;
    end else begin
      any_rise_q <= |rising_pulse;
    end
  end

  assign any_rise = any_rise_q;

endmodule
